// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and widths, used by fetch, decode and hazard logic.
package cpu_pkg;

  localparam int ADDR_W = 30;
  localparam int INSTR_W = 32;
  localparam int PERF_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus1;
  } ifid_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fbuf_t;

  localparam ifid_t IFID_RST = '{instr: NOP_INSTR, pc: '0, pc_plus1: '0};

  // Word-address increment, wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with valid bit: flush/hold/load, invalid entries show RST_VAL.
// Latency: one cycle from load to q.
// Backpressure: hold freezes contents; caller derives hold from downstream stall.
module ifid_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Without hold or load the entry has been consumed, so it becomes a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      q     <= RST_VAL;
    end else if (!hold) begin
      valid <= load;
      q     <= load ? d : RST_VAL;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives pc_d, issues imem req/ack, fills IF/ID; FETCH_PERF_EN adds stall/flush counters.
// Latency: instruction appears on ifid_* the edge after its imem_ack cycle.
// Backpressure: id_stall holds IF/ID; one extra returned word parks in a buffer (HOLD) and pc_d freezes.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  pc_d,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               id_stall,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus1
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]  stall_cycles,
  output logic [PERF_W-1:0]  flush_count
`endif
);

  fetch_state_t      state, state_nxt;
  fbuf_t             hbuf_q;
  logic              hbuf_ld;
  logic [ADDR_W-1:0] redir_q;
  logic              redir_ld;
  logic              accept;
  logic              ld;
  ifid_t             ld_dat;
  ifid_t             ifid_q;

  assign accept    = !ifid_valid || !id_stall;
  assign imem_addr = pc_q;

  always_comb begin
    state_nxt = state;
    pc_d      = pc_q;
    imem_req  = 1'b0;
    hbuf_ld   = 1'b0;
    redir_ld  = 1'b0;
    ld        = 1'b0;
    ld_dat    = '{instr: imem_rdata, pc: pc_q, pc_plus1: pc_inc(pc_q)};
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect && imem_ack) begin
          pc_d = redirect_target;
        end else if (redirect) begin
          redir_ld  = 1'b1;
          state_nxt = DROP;
        end else if (imem_ack) begin
          pc_d = pc_inc(pc_q);
          if (accept) begin
            ld = 1'b1;
          end else begin
            hbuf_ld   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        ld_dat = '{instr: hbuf_q.instr, pc: hbuf_q.pc, pc_plus1: pc_inc(hbuf_q.pc)};
        if (redirect) begin
          pc_d      = redirect_target;
          state_nxt = FETCH;
        end else if (accept) begin
          ld        = 1'b1;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // The stale request must complete at its original address before refetching.
        imem_req = 1'b1;
        redir_ld = redirect;
        if (imem_ack) begin
          pc_d      = redirect ? redirect_target : redir_q;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hbuf_q  <= '{instr: NOP_INSTR, pc: '0};
      redir_q <= '0;
    end else begin
      state <= state_nxt;
      if (hbuf_ld) hbuf_q <= '{instr: imem_rdata, pc: pc_q};
      if (redir_ld) redir_q <= redirect_target;
    end
  end

  ifid_reg #(
    .W       ($bits(ifid_t)),
    .RST_VAL (IFID_RST)
  ) u_ifid (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .hold  (ifid_valid && id_stall),
    .load  (ld),
    .d     (ld_dat),
    .valid (ifid_valid),
    .q     (ifid_q)
  );

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus1 = ifid_q.pc_plus1;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (ifid_valid && id_stall && stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
      if (redirect && flush_count != '1) flush_count <= flush_count + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU, directly downstream of the pc register, which it also feeds.
- Takes the current word-address PC (pc_q) and issues a req/ack fetch to instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Drives the next PC (pc_d) back into the pc register's input. The pc register has no enable, so holding means pc_d = pc_q.
- Handles decode back-pressure (id_stall) and branch/jump redirects from EX, including a redirect that arrives while a fetch is in flight.

Parameters:
ADDR_W, 30, word-address width (byte address = {addr, 2'b00})
INSTR_W, 32, instruction width
NOP_INSTR, 32'h00000000, value driven on ifid_instr when invalid / after reset
PERF_W, 32, width of the perf counters (FETCH_PERF_EN only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
pc_q  in  ADDR_W  current PC from the pc register
pc_d  out  ADDR_W  next PC to the pc register input
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch word address
imem_ack  in  1  data valid this cycle; completes the request
imem_rdata  in  INSTR_W  fetched instruction
redirect  in  1  taken branch/jump from EX; flush
redirect_target  in  ADDR_W  redirect word address
id_stall  in  1  decode cannot accept a new instruction
ifid_valid  out  1  IF/ID holds a valid instruction
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc  out  ADDR_W  PC of ifid_instr
ifid_pc_plus1  out  ADDR_W  ifid_pc+1 (link/branch base)

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus1=0, buffer empty.
  - imem_req=0 and pc_d=pc_q (combinational) while in IDLE.
  - Reset mid-request abandons it; any later ack in IDLE is ignored.
- accept = !ifid_valid || !id_stall.
- IF/ID register:
  - Holds all fields when ifid_valid && id_stall && !redirect.
  - Clears ifid_valid to 0 on the edge after redirect=1; redirect beats stall.
  - Invalid entries drive NOP_INSTR.
- IDLE: one cycle, then FETCH. imem_req=0, pc_d=pc_q.
- FETCH: imem_req=1, imem_addr=pc_q. imem_addr stays stable until ack. Cases, in priority order:
  - redirect && imem_ack: data dropped; pc_d=redirect_target; stay FETCH.
  - redirect && !imem_ack: redir_q<=redirect_target; pc_d=pc_q; go DROP.
  - imem_ack && accept: load IF/ID with {rdata, pc_q, pc_q+1}, valid=1; pc_d=pc_q+1. Sustains 1 instr/cycle with zero-wait memory.
  - imem_ack && !accept: buf<={rdata, pc_q}; pc_d=pc_q+1; go HOLD.
  - no ack: pc_d=pc_q.
- HOLD: imem_req=0, pc_d=pc_q.
  - redirect: discard buf; pc_d=redirect_target; go FETCH.
  - else accept: buf moves into IF/ID, valid=1; go FETCH.
- DROP: imem_req=1, imem_addr=pc_q (old address), pc_d=pc_q.
  - Further redirect overwrites redir_q (newest wins).
  - On ack: data dropped; pc_d=redir_q, or redirect_target if redirect is asserted that same cycle; go FETCH.
- Latency: instruction visible on ifid_* the edge after the ack cycle.
- Arithmetic: pc+1 is modulo 2^ADDR_W; 30'h3FFFFFFF+1 = 0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output stall_cycles[PERF_W] (counts cycles with ifid_valid && id_stall) and output flush_count[PERF_W] (counts cycles with redirect=1). Both reset to 0, saturate at all-ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package cpu_pkg: ADDR_W, INSTR_W, NOP_INSTR, and fetch_state_t {IDLE, FETCH, HOLD, DROP}, shared with decode and hazard logic.
- Sub-module ifid_reg: IF/ID register with load/hold/flush controls and reset to NOP. It is reused for the pipeline registers of later stages.

Test Plan:
- Reset, zero-wait memory, pc_q follows pc_d from 0 -> pc_d = 1,2,3; ifid_pc = 0,1,2 on consecutive cycles; ifid_instr = memory words.
- id_stall=1 for 3 cycles with ifid_valid=1 -> IF/ID holds; one word goes to HOLD; pc_d frozen. After release, the buffered word (pc=5) appears next cycle with no loss or duplication.
- redirect to 30'h100 with ack in the same cycle -> pc_d=0x100; ifid_valid=0 next cycle; the next valid ifid_pc=0x100.
- imem_ack delayed 3 cycles; redirect to 0x40 in wait cycle 1, then to 0x80 in wait cycle 2 -> imem_addr stable, returned data dropped, next fetch address = 0x80.
- pc_q=30'h3FFFFFFF fetched -> pc_d=0, ifid_pc_plus1=0.
- Reset asserted during DROP -> IDLE, ifid_valid=0, imem_req=0 next cycle; a late ack is ignored. With FETCH_PERF_EN, counters read 0.
